uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised UART serialiser, the next generation of the fixed 8N1 transmitter. It adds configurable data width, parity and stop-bit count, a valid/ready input handshake and a synchronous reset. It sits between the APB-side register logic and the board TX pin, one instance per UART channel. An optional input FIFO decouples bursty writes from the serial line.

Parameters:
CLKS_PER_BIT, 868, clock cycles per serial bit; legal range >= 2.
DATA_BITS, 8, payload bits per frame; legal range 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.
FIFO_DEPTH, 4, FIFO entries when UART_TX_FIFO_EN is defined; must be a power of 2 and >= 2.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
din  in  DATA_BITS  payload word, LSB transmitted first
valid  in  1  din is valid this cycle
ready  out  1  block accepts din this cycle
dout  out  1  serial TX line, idles high
tx_busy  out  1  a frame is in progress (START through last STOP)
done  out  1  one-cycle pulse when a frame completes

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. Every output is registered except ready.
- Reset values: dout=1, tx_busy=0, done=0, state=IDLE, all counters=0, FIFO empty. Reset takes priority over all other activity.
- Reset mid-frame aborts the frame. dout=1 on the cycle after rst is sampled high. No done pulse is generated.
- Handshake: a transfer occurs when valid && ready on a clk edge. din is captured into the shift register at that edge; later changes to din are ignored. valid is held or dropped by the source without penalty.
- ready without FIFO: (state==IDLE) && !rst, combinational.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: dout=1, tx_busy=0. On a transfer, go to START next cycle with tx_busy=1.
- START: dout=0 for CLKS_PER_BIT cycles.
- DATA: DATA_BITS bits, each held CLKS_PER_BIT cycles, LSB first, shifted out of the captured word.
- PARITY: only when PARITY != 0; one bit time.
  - Odd: the parity bit makes the total count of 1s over data plus parity odd.
  - Even: the parity bit makes that total even.
  - Parity is computed from the captured word, not from live din.
- STOP: dout=1 for STOP_BITS*CLKS_PER_BIT cycles, then return to IDLE.
- Completion cycle: on the first cycle back in IDLE, done=1 for exactly one cycle and tx_busy=0.
- Latency: dout falls on the first clk edge after the accepting edge.
- Frame length: CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles of dout activity.
- Back-to-back frames: valid held high is accepted in the done/IDLE cycle. Minimum line-high gap between frames is therefore stop time + 1 clk.
- Bit timer: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps on every bit boundary without drift.
- Bit index counter: width $clog2(DATA_BITS+1).
- Illegal parameters: stop elaboration with $error.

Optional Feature:
UART_TX_FIFO_EN
- Defined:
  - A FIFO_DEPTH x DATA_BITS FIFO sits in front of the serialiser.
  - ready = !full && !rst.
  - A push occurs on valid && ready.
  - The serialiser pops when it is in IDLE and the FIFO is not empty; it enters START on the next cycle.
  - A push to an empty FIFO starts the frame 2 cycles after the accepting edge.
  - Simultaneous push and pop are legal; the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - rst flushes the FIFO.
  - done and tx_busy are per frame, as above.
- Undefined: no storage is instantiated; ready follows the IDLE-state rule and latency is 1 cycle.

Test Plan:
- Reset: assert rst 3 cycles, valid=0 -> dout=1, tx_busy=0, done=0, ready=1 after release.
- CLKS_PER_BIT=4, DATA_BITS=8, PARITY=2, STOP_BITS=1, din=8'hA5 -> dout sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles (44 total). done pulses once on cycle 45 after the handshake.
- PARITY=1, DATA_BITS=7, din=7'h07 -> parity bit 0; with PARITY=2 the same din gives parity bit 1. STOP_BITS=2 -> dout high 8 cycles.
- Back-to-back: valid held with 8'h00 then 8'hFF -> second start bit begins exactly 1 clk after the first frame's done. No frame is lost and ready is low throughout each frame.
- Mid-frame reset: rst pulsed 1 cycle during DATA bit 3 -> dout=1 next cycle, no done pulse, next transfer produces a clean full frame.
- UART_TX_FIFO_EN, FIFO_DEPTH=4: push 5 words on consecutive cycles -> ready drops after the fourth push into the full FIFO. All accepted words appear in order; done pulses 5 times once the fifth word is accepted after a pop.

Source files
------------

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART serialiser with a valid/ready input.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO before it.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 valid,
  output logic                 ready,
  output logic                 dout,
  output logic                 tx_busy,
  output logic                 done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fd
    $error("uart_tx_param: FIFO_DEPTH must be a power of 2, >= 2");
  end

  logic [2:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_dout;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_load;
  logic [DATA_BITS-1:0] w_ld_data;
  logic                 w_tick;
  logic                 w_line;

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr;
  logic [AW-1:0]        r_rd;
  logic [AW:0]          r_fcnt;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;

  assign w_full    = (r_fcnt == FIFO_DEPTH[AW:0]);
  assign w_empty   = (r_fcnt == '0);
  assign ready     = !w_full && !rst;
  assign w_push    = valid && ready;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign w_load    = w_pop;
  assign w_ld_data = r_mem[r_rd];

  // FIFO pointers and occupancy; push and pop together leave count as is
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  // FIFO storage, written on every accepted word
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end
`else
  assign ready     = (r_state == S_IDLE) && !rst;
  assign w_load    = valid && ready;
  assign w_ld_data = din;
`endif

  assign w_tick  = (r_cnt == CW'(CLKS_PER_BIT - 1));
  assign dout    = r_dout;
  assign tx_busy = r_busy;
  assign done    = r_done;

  // Line level implied by the current state; registered into dout
  always_comb begin
    w_line = 1'b1;
    unique case (r_state)
      S_START: w_line = 1'b0;
      S_DATA:  w_line = r_shift[0];
      S_PAR:   w_line = r_par;
      default: w_line = 1'b1;
    endcase
  end

  // Frame sequencer: bit timer, bit index and state transitions
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_dout  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_dout <= w_line;
      r_done <= 1'b0;
      if (r_state != S_IDLE) begin
        r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
          if (w_load) begin
            r_state <= S_START;
            r_shift <= w_ld_data;
            r_par   <= (^w_ld_data) ^ (PARITY == 1);
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_tick) r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift <= r_shift >> 1;
            if (r_idx == IW'(DATA_BITS - 1)) begin
              r_idx   <= '0;
              r_state <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_PAR: begin
          if (w_tick) r_state <= S_STOP;
        end
        S_STOP: begin
          if (w_tick) begin
            if (r_idx == IW'(STOP_BITS - 1)) begin
              r_idx   <= '0;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed checks of uart_tx_param frames and handshake.
// Three instances cover parity/width/stop variants; FIFO build adds a burst.
module tb_uart_tx_param;

`ifdef UART_TX_FIFO_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] din;
  logic [2:0] valid;
  logic [2:0] ready;
  logic [2:0] dout;
  logic [2:0] busy;
  logic [2:0] done;

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;

  always #5 clk = ~clk;

  uart_tx_param #(
    .CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2),
    .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_a (
    .clk(clk), .rst(rst), .din(din[7:0]), .valid(valid[0]),
    .ready(ready[0]), .dout(dout[0]), .tx_busy(busy[0]),
    .done(done[0])
  );

  uart_tx_param #(
    .CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1),
    .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u_b (
    .clk(clk), .rst(rst), .din(din[6:0]), .valid(valid[1]),
    .ready(ready[1]), .dout(dout[1]), .tx_busy(busy[1]),
    .done(done[1])
  );

  uart_tx_param #(
    .CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2),
    .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u_c (
    .clk(clk), .rst(rst), .din(din[6:0]), .valid(valid[2]),
    .ready(ready[2]), .dout(dout[2]), .tx_busy(busy[2]),
    .done(done[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (done[0] === 1'b1) n_done++;
  endtask

  task automatic send(input int k, input logic [8:0] d, input bit hold);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    din = d;
    valid[k] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (ready[k] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("accept%0d", k), 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) valid[k] = 1'b0;
  endtask

  // bits: frame line levels, bit 0 = start bit; checks every cycle
  task automatic frame(input int k, input logic [15:0] bits,
                       input int nb, input bit b2b);
    int t;
    int s;
    int last;
    logic e_dout, e_busy, e_done, e_rdy;
    t = 4 * nb;
    last = t + LAT + (b2b ? 1 : 2);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      s = c - LAT;
      e_busy = (s >= 1 && s <= t);
      e_done = (s == t + 1);
      e_dout = (s >= 2 && s <= t + 1) ? bits[(s - 2) / 4] : 1'b1;
      e_rdy  = (LAT == 1) ? 1'b1 : !(s >= 1 && s <= t);
      chk($sformatf("frm%0d_c%0d", k, c),
          {28'd0, dout[k], busy[k], done[k], ready[k]},
          {28'd0, e_dout, e_busy, e_done, e_rdy});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int seen;
    rst = 1'b1;
    din = '0;
    valid = '0;

    // reset held three cycles
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold", {28'd0, dout[0], busy[0], done[0], ready[0]},
        32'b1000);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_rel%0d", k),
          {28'd0, dout[k], busy[k], done[k], ready[k]}, 32'b1001);
    end

    // 8 data bits, even parity: 0,10100101 LSB first,0,1
    send(0, 9'h0A5, 1'b0);
    frame(0, 16'h054A, 11, 1'b0);

    // 7 data bits, odd parity -> 0, two stop bits
    send(1, 9'h007, 1'b0);
    frame(1, 16'h060E, 11, 1'b0);

    // same word, even parity -> 1
    send(2, 9'h007, 1'b0);
    frame(2, 16'h070E, 11, 1'b0);

`ifndef UART_TX_FIFO_EN
    // back-to-back with valid held: 00 then FF
    send(0, 9'h000, 1'b1);
    din = 9'h0FF;
    frame(0, 16'h0400, 11, 1'b1);
    @(posedge clk);
    #1 valid[0] = 1'b0;
    frame(0, 16'h05FE, 11, 1'b0);
`endif

    // reset pulse in the middle of data bit 3
    send(0, 9'h0A5, 1'b0);
    for (int c = 1; c <= 19 + LAT; c++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_line", {29'd0, dout[0], busy[0], done[0]}, 32'b100);
    chk("midrst_rdy", 32'(ready[0]), 32'd1);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done[0] === 1'b1) seen++;
    end
    chk("midrst_nodone", 32'(seen), 32'd0);
    send(0, 9'h03C, 1'b0);
    frame(0, 16'h0478, 11, 1'b0);

`ifdef UART_TX_FIFO_EN
    begin
      logic [7:0] wds [5];
      logic       pars [5];
      wds[0] = 8'h01; pars[0] = 1'b1;
      wds[1] = 8'h22; pars[1] = 1'b0;
      wds[2] = 8'h37; pars[2] = 1'b1;
      wds[3] = 8'h80; pars[3] = 1'b1;
      wds[4] = 8'hFF; pars[4] = 1'b0;
      n_done = 0;
      @(negedge clk);
      fork
        begin
          valid[0] = 1'b1;
          for (int i = 0; i < 5; i++) begin
            din = {1'b0, wds[i]};
            chk($sformatf("fifo_rdy%0d", i), 32'(ready[0]), 32'd1);
            @(posedge clk);
            #1;
          end
          valid[0] = 1'b0;
          @(negedge clk);
          chk("fifo_full", 32'(ready[0]), 32'd0);
        end
        begin
          for (int f = 0; f < 5; f++) begin
            logic [10:0] fb;
            bit got;
            fb = '0;
            got = 1'b0;
            for (int i = 0; i < 400; i++) begin
              tick();
              if (dout[0] === 1'b0) begin
                got = 1'b1;
                break;
              end
            end
            chk($sformatf("fifo_start%0d", f), 32'(got), 32'd1);
            for (int b = 1; b <= 10; b++) begin
              repeat (4) tick();
              fb[b] = dout[0];
            end
            chk($sformatf("fifo_w%0d", f), 32'(fb[8:1]), 32'(wds[f]));
            chk($sformatf("fifo_p%0d", f), 32'(fb[9]), 32'(pars[f]));
            chk($sformatf("fifo_s%0d", f), 32'(fb[10]), 32'd1);
          end
          repeat (10) tick();
        end
      join
      chk("fifo_ndone", 32'(n_done), 32'd5);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
